// File: rtl/led_blinker_bank.sv
// led_blinker_bank: NUM_CH independent LED channels (OFF/TOGGLE/PWM/ONESHOT).
// Optional macro LED_BANK_WRAP_PULSE_EN adds the o_Wrap per-channel wrap pulse.
module led_blinker_bank #(
  parameter int NUM_CH         = 4,
  parameter int CNT_W          = 32,
  parameter int DEFAULT_PERIOD = 12500000,
  localparam int CH_W          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              i_Clk,
  input  logic              i_Rst,
  input  logic              i_Cfg_Wr,
  input  logic [CH_W-1:0]   i_Cfg_Ch,
  input  logic [1:0]        i_Cfg_Mode,
  input  logic [CNT_W-1:0]  i_Cfg_Period,
  input  logic [CNT_W-1:0]  i_Cfg_Duty,
  input  logic [NUM_CH-1:0] i_Enable,
  input  logic              i_Sync,
  output logic [NUM_CH-1:0] o_LED
`ifdef LED_BANK_WRAP_PULSE_EN
  ,
  output logic [NUM_CH-1:0] o_Wrap
`endif
);

  localparam logic [1:0] MODE_OFF     = 2'b00;
  localparam logic [1:0] MODE_TOGGLE  = 2'b01;
  localparam logic [1:0] MODE_PWM     = 2'b10;
  localparam logic [1:0] MODE_ONESHOT = 2'b11;

  localparam logic [CNT_W-1:0] DEF_P = CNT_W'(DEFAULT_PERIOD);
  localparam logic [CNT_W-1:0] DEF_D = CNT_W'(DEFAULT_PERIOD / 2);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

  for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
    logic [1:0]       mode_q;
    logic [CNT_W-1:0] per_q;
    logic [CNT_W-1:0] duty_q;
    logic [CNT_W-1:0] cnt_q;
    logic             led_q;
    logic             hit;
    logic             clr;
    logic             run;
    logic [CNT_W-1:0] pm1;
    logic             last;
    logic             is_tog;
    logic             is_pwm;
    logic             is_one;

    // Out-of-range channel numbers never match, so such writes fall away.
    assign hit    = i_Cfg_Wr && (i_Cfg_Ch == CH_W'(n));
    assign clr    = hit || i_Sync;
    assign run    = i_Enable[n];
    // Period 0 acts as 1, so the last count is 0 rather than all ones.
    assign pm1    = (per_q == '0) ? '0 : per_q - ONE;
    assign last   = (cnt_q >= pm1);
    assign is_tog = (mode_q == MODE_TOGGLE);
    assign is_pwm = (mode_q == MODE_PWM);
    assign is_one = (mode_q == MODE_ONESHOT);

    // Channel configuration registers: reset defaults, replaced by a write.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
      if (i_Rst) begin
        mode_q <= MODE_TOGGLE;
        per_q  <= DEF_P;
        duty_q <= DEF_D;
      end else if (hit) begin
        mode_q <= i_Cfg_Mode;
        per_q  <= i_Cfg_Period;
        duty_q <= i_Cfg_Duty;
      end
    end

    // Counter and LED bit: restart on write/sync, otherwise run the mode.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
      if (i_Rst) begin
        cnt_q <= '0;
        led_q <= 1'b0;
      end else if (clr || mode_q == MODE_OFF) begin
        cnt_q <= '0;
        led_q <= 1'b0;
      end else if (run) begin
        unique case (1'b1)
          is_tog: begin
            if (last) begin
              cnt_q <= '0;
              led_q <= ~led_q;
            end else begin
              cnt_q <= cnt_q + ONE;
            end
          end
          is_pwm: begin
            led_q <= (cnt_q < duty_q);
            cnt_q <= last ? '0 : cnt_q + ONE;
          end
          is_one: begin
            if (cnt_q < duty_q) begin
              led_q <= 1'b1;
              cnt_q <= cnt_q + ONE;
            end else begin
              led_q <= 1'b0;
            end
          end
          default: begin
            cnt_q <= '0;
            led_q <= 1'b0;
          end
        endcase
      end
    end

    assign o_LED[n] = led_q;

`ifdef LED_BANK_WRAP_PULSE_EN
    logic wrap_q;

    // One-clock pulse on the edge that wraps the counter or ends a one-shot.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
      if (i_Rst) begin
        wrap_q <= 1'b0;
      end else begin
        wrap_q <= !clr && run &&
                  (((is_tog || is_pwm) && last) ||
                   (is_one && (cnt_q < duty_q) &&
                    (cnt_q == duty_q - ONE)));
      end
    end

    assign o_Wrap[n] = wrap_q;
`endif
  end

endmodule
